// File: rtl/reg_bank_pkg.sv
// Shared constants, types and helpers for the four-entry register bank.
package reg_bank_pkg;

    localparam int unsigned REG_ADDR_W = 2;
    localparam int unsigned NUM_REGS   = 4;
    localparam int unsigned WQ_DEPTH   = 2;
    localparam int unsigned DEF_DATA_W = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Write-queue entry at the default data width. The RTL modules build the same
    // layout at their own DATA_W.
    typedef struct packed {
        reg_addr_t             addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_entry_t;

    // True when a queue holding 'count' entries cannot take another write.
    function automatic logic wq_full(input logic [1:0] count);
        return {30'b0, count} >= WQ_DEPTH;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Write-port handshake, stall and read-port bundle of the register bank.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 8
);
    logic              wrValid;
    logic              wrReady;
    reg_addr_t         wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              stall;
    reg_addr_t         rdAddr1;
    reg_addr_t         rdAddr2;
    logic [DATA_W-1:0] rdData1;
    logic [DATA_W-1:0] rdData2;
    logic [1:0]        pendCount;

    // Source side: the track selector and write-back path.
    modport master (
        output wrValid, wrAddr, wrData, stall, rdAddr1, rdAddr2,
        input  wrReady, rdData1, rdData2, pendCount
    );

    // Register bank side.
    modport slave (
        input  wrValid, wrAddr, wrData, stall, rdAddr1, rdAddr2,
        output wrReady, rdData1, rdData2, pendCount
    );
endinterface

// File: rtl/reg_wq.sv
// Two-entry write queue. Slot 0 always holds the oldest entry (head); slot 1 holds
// the newest entry when two are queued.
module reg_wq
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  reg_addr_t         i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic              o_head_valid,
    output reg_addr_t         o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_tail_valid,
    output reg_addr_t         o_tail_addr,
    output logic [DATA_W-1:0] o_tail_data
);

    typedef struct packed {
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     r_slot0;
    entry_t     r_slot1;
    logic [1:0] r_count;

    entry_t     w_new;
    logic       w_push;
    logic       w_pop;

    assign w_new  = '{addr: i_push_addr, data: i_push_data};
    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push & (r_count != 2'd2);
    assign w_pop  = i_pop & (r_count != 2'd0);

    // Shift-register FIFO update: pops move slot 1 into slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= w_new;
                    end else begin
                        r_slot1 <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= w_new;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = (r_count != 2'd0);
    assign o_head_addr  = r_slot0.addr;
    assign o_head_data  = r_slot0.data;
    // Slot 1 is only a distinct, newer entry when both slots are occupied.
    assign o_tail_valid = (r_count == 2'd2);
    assign o_tail_addr  = r_slot1.addr;
    assign o_tail_data  = r_slot1.data;

endmodule

// File: rtl/reg_bank.sv
// Four-entry register bank: storage array, queue commit and two forwarding read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    reg_bank_if.slave io_bus
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [1:0]        w_count;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;
    reg_addr_t         w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_tail_valid;
    reg_addr_t         w_tail_addr;
    logic [DATA_W-1:0] w_tail_data;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Ready depends only on the registered count; no same-cycle pass-through when full.
    assign w_ready = !wq_full(w_count);
    assign w_push  = io_bus.wrValid & w_ready;
    assign w_pop   = w_head_valid & !io_bus.stall;

    reg_wq #(
        .DATA_W (DATA_W)
    ) u_wq (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_addr  (io_bus.wrAddr),
        .i_push_data  (io_bus.wrData),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_tail_valid (w_tail_valid),
        .o_tail_addr  (w_tail_addr),
        .o_tail_data  (w_tail_data)
    );

    // Commit the queue head into the array unless stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_pop) begin
            r_regs[w_head_addr] <= w_head_data;
        end
    end

    // Newest matching queued entry wins, then the array value.
    function automatic logic [DATA_W-1:0] fwd_read(
        input reg_addr_t         addr,
        input logic              tail_valid,
        input reg_addr_t         tail_addr,
        input logic [DATA_W-1:0] tail_data,
        input logic              head_valid,
        input reg_addr_t         head_addr,
        input logic [DATA_W-1:0] head_data,
        input logic [DATA_W-1:0] arr_data
    );
        if (tail_valid && (tail_addr == addr)) begin
            return tail_data;
        end else if (head_valid && (head_addr == addr)) begin
            return head_data;
        end
        return arr_data;
    endfunction

    // Read port 1 forwarding mux.
    always_comb begin
        w_rd1 = fwd_read(io_bus.rdAddr1, w_tail_valid, w_tail_addr, w_tail_data,
                         w_head_valid, w_head_addr, w_head_data, r_regs[io_bus.rdAddr1]);
    end

    // Read port 2 forwarding mux.
    always_comb begin
        w_rd2 = fwd_read(io_bus.rdAddr2, w_tail_valid, w_tail_addr, w_tail_data,
                         w_head_valid, w_head_addr, w_head_data, r_regs[io_bus.rdAddr2]);
    end

    assign io_bus.wrReady   = w_ready;
    assign io_bus.rdData1   = w_rd1;
    assign io_bus.rdData2   = w_rd2;
    assign io_bus.pendCount = w_count;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, reset corner cases and
// randomized traffic against a queue-based reference model.
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_bank_if #(.DATA_W(8)) bus_if ();

    reg_bank #(
        .DATA_W (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [7:0] d;
        logic       s;
        logic [1:0] r1;
        logic [1:0] r2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       er;
        logic [1:0] ep;
    } vec_t;

    vec_t vq[$];

    // Reference model: ordered list of pending writes plus the committed array.
    wr_entry_t  mq[$];
    logic [7:0] marr [4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [7:0] d,
                         input logic s, input logic [1:0] r1, input logic [1:0] r2);
        bus_if.wrValid = v;
        bus_if.wrAddr  = a;
        bus_if.wrData  = d;
        bus_if.stall   = s;
        bus_if.rdAddr1 = r1;
        bus_if.rdAddr2 = r2;
    endtask

    function automatic logic [7:0] model_rd(input logic [1:0] a);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == a) return mq[i].data;
        end
        return marr[a];
    endfunction

    task automatic model_edge(input logic v, input logic [1:0] a, input logic [7:0] d,
                              input logic s);
        bit acc;
        bit com;
        wr_entry_t e;
        acc = v && (mq.size() < 2);
        com = (mq.size() > 0) && !s;
        if (com) begin
            e = mq.pop_front();
            marr[e.addr] = e.data;
        end
        if (acc) mq.push_back('{addr: a, data: d});
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                                 input logic er, input logic [1:0] ep);
        chk({tag, " rdData1"}, int'(bus_if.rdData1), int'(e1));
        chk({tag, " rdData2"}, int'(bus_if.rdData2), int'(e2));
        chk({tag, " wrReady"}, int'(bus_if.wrReady), int'(er));
        chk({tag, " pendCount"}, int'(bus_if.pendCount), int'(ep));
    endtask

    initial begin
        // Directed sequence, starting right after reset. Expected values are the
        // combinational outputs during the row's cycle, before its rising edge.
        //            v     a     d      s     r1    r2    e1     e2     er    ep
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 2'd0});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd3, 8'h00, 8'h00, 1'b1, 2'd0});
        vq.push_back('{1'b1, 2'd2, 8'h5A, 1'b0, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 2'd0});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd0, 8'h5A, 8'h00, 1'b1, 2'd1});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd2, 8'h5A, 8'h5A, 1'b1, 2'd0});
        vq.push_back('{1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 2'd0});
        vq.push_back('{1'b1, 2'd1, 8'h22, 1'b1, 2'd1, 2'd2, 8'h11, 8'h5A, 1'b1, 2'd1});
        vq.push_back('{1'b1, 2'd1, 8'h33, 1'b1, 2'd1, 2'd1, 8'h22, 8'h22, 1'b0, 2'd2});
        vq.push_back('{1'b1, 2'd1, 8'h33, 1'b0, 2'd1, 2'd2, 8'h22, 8'h5A, 1'b0, 2'd2});
        vq.push_back('{1'b1, 2'd1, 8'h33, 1'b0, 2'd1, 2'd1, 8'h22, 8'h22, 1'b1, 2'd1});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd3, 8'h33, 8'h00, 1'b1, 2'd1});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd2, 8'h33, 8'h5A, 1'b1, 2'd0});
        vq.push_back('{1'b1, 2'd0, 8'h7F, 1'b1, 2'd0, 2'd1, 8'h00, 8'h33, 1'b1, 2'd0});
        vq.push_back('{1'b1, 2'd3, 8'hC3, 1'b0, 2'd0, 2'd3, 8'h7F, 8'h00, 1'b1, 2'd1});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 8'h7F, 8'hC3, 1'b1, 2'd1});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd0, 8'hC3, 8'h7F, 1'b1, 2'd1});
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd2, 8'hC3, 8'h5A, 1'b1, 2'd0});

        // Reset state for every address.
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3);
        #3;
        for (int i = 0; i < 4; i++) begin
            bus_if.rdAddr1 = 2'(i);
            bus_if.rdAddr2 = 2'(3 - i);
            #1;
            check_outputs($sformatf("reset addr%0d", i), 8'h00, 8'h00, 1'b1, 2'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].v, vq[i].a, vq[i].d, vq[i].s, vq[i].r1, vq[i].r2);
            #2;
            check_outputs($sformatf("vec%0d", i), vq[i].e1, vq[i].e2, vq[i].er, vq[i].ep);
            @(posedge clk);
            #1;
        end

        // Fill the queue under stall, then reset asynchronously mid-cycle.
        drive(1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 2'd2);
        @(posedge clk);
        #1;
        drive(1'b1, 2'd2, 8'hBB, 1'b1, 2'd0, 2'd2);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd2);
        #1;
        check_outputs("full before rst", 8'hAA, 8'hBB, 1'b0, 2'd2);
        rst = 1'b1;
        #1;
        check_outputs("async rst", 8'h00, 8'h00, 1'b1, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus_if.rdAddr1 = 2'(i);
            bus_if.rdAddr2 = 2'((i + 1) % 4);
            #1;
            check_outputs($sformatf("post rst addr%0d", i), 8'h00, 8'h00, 1'b1, 2'd0);
        end

        // Randomized traffic against the reference model, starting from the cleared state.
        mq.delete();
        for (int i = 0; i < 4; i++) marr[i] = 8'h00;
        for (int n = 0; n < 400; n++) begin
            logic       v;
            logic [1:0] a;
            logic [7:0] d;
            logic       s;
            logic [1:0] r1;
            logic [1:0] r2;
            v  = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            s  = ($urandom_range(0, 2) == 0);
            r1 = 2'($urandom_range(0, 3));
            r2 = 2'($urandom_range(0, 3));
            drive(v, a, d, s, r1, r2);
            #2;
            check_outputs($sformatf("rand%0d", n), model_rd(r1), model_rd(r2),
                          (mq.size() < 2), 2'(mq.size()));
            @(posedge clk);
            model_edge(v, a, d, s);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
